// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for the RV32E data memory group.
// Issues loads/stores from a valid/ready request port, tracks loads through
// the fixed memory read latency, extends the returned data and buffers the
// results in a small response FIFO.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// and illegal-width requests (fault pulse plus fault_addr capture).
module load_store_unit #(
    parameter int  DATA_DEPTH  = 4096,
    parameter int  MEM_LATENCY = 3,
    parameter int  RSP_DEPTH   = MEM_LATENCY + 1,
    localparam int AW          = 2 + $clog2(DATA_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,
    input  logic [3:0]    req_rd_i,
    input  logic          flush_i,
    output logic          mem_we_o,
    output logic [1:0]    mem_data_width_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_write_data_o,
    input  logic [31:0]   mem_read_data_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [3:0]    rsp_rd_o,
    output logic [31:0]   rsp_data_o,
    output logic          fault_o,
    output logic [AW-1:0] fault_addr_o
);

    localparam logic [1:0] DATAWIDTH_BYTE  = 2'd0;
    localparam logic [1:0] DATAWIDTH_SHORT = 2'd1;
    localparam logic [1:0] DATAWIDTH_WORD  = 2'd2;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                   acc;
    logic                   squash;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [31:0]            push_data;
    int unsigned            occupancy;

    logic [MEM_LATENCY-1:0] trk_vld_q, trk_vld_d;
    logic [3:0]             trk_rd_q [MEM_LATENCY];
    logic [2:0]             trk_f3_q [MEM_LATENCY];

    logic [3:0]             fifo_rd_q   [RSP_DEPTH];
    logic [31:0]            fifo_data_q [RSP_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    // Sign- or zero-extend the addressed byte/half; words pass through.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = raw[7:0];
        h = raw[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, raw[7:0]}  : 32'(b);
            2'b01:   r = f3[2] ? {16'd0, raw[15:0]} : 32'(h);
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request decode: credit check, accept, and whether the request reaches memory.
    always_comb begin
        occupancy = {{(32-CW){1'b0}}, cnt_q};
        for (int i = 0; i < MEM_LATENCY; i++) begin
            occupancy = occupancy + {31'd0, trk_vld_q[i]};
        end
        // Loads must have a guaranteed FIFO slot; a same-cycle pop is not credited.
        req_ready_o = !rst && !flush_i && (req_we_i || (occupancy < 32'(RSP_DEPTH)));
        acc         = req_valid_i && req_ready_o;
`ifdef LSU_MISALIGN_TRAP_EN
        squash = (req_funct3_i[1:0] == 2'b11)
              || ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
              || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
        // Illegal width is accepted and silently dropped.
        squash = (req_funct3_i[1:0] == 2'b11);
`endif
        issue = acc && !squash;
        case (req_funct3_i[1:0])
            2'b00:   mem_data_width_o = DATAWIDTH_BYTE;
            2'b01:   mem_data_width_o = DATAWIDTH_SHORT;
            2'b10:   mem_data_width_o = DATAWIDTH_WORD;
            default: mem_data_width_o = DATAWIDTH_BYTE;
        endcase
    end

    assign mem_we_o         = issue && req_we_i;
    assign mem_addr_o       = req_addr_i;
    assign mem_write_data_o = req_wdata_i;

    // Tracking valid chain: a load enters at stage 0; flush empties it.
    always_comb begin
        trk_vld_d    = '0;
        trk_vld_d[0] = issue && !req_we_i && !flush_i;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1] && !flush_i;
        end
    end

    // Tracking valid register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_vld_q <= '0;
        end else begin
            trk_vld_q <= trk_vld_d;
        end
    end

    // Tracking payload shifts every cycle; only entries with a valid bit matter.
    always_ff @(posedge clk) begin
        trk_rd_q[0] <= req_rd_i;
        trk_f3_q[0] <= req_funct3_i;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            trk_rd_q[i] <= trk_rd_q[i-1];
            trk_f3_q[i] <= trk_f3_q[i-1];
        end
    end

    assign push        = trk_vld_q[MEM_LATENCY-1] && !flush_i;
    assign push_data   = extend(trk_f3_q[MEM_LATENCY-1], mem_read_data_i);
    assign rsp_valid_o = (cnt_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i && !flush_i;
    assign rsp_rd_o    = rsp_valid_o ? fifo_rd_q[rd_ptr_q]   : '0;
    assign rsp_data_o  = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;

    // Response FIFO pointer/count next state; flush drops all buffered responses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Response FIFO control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Response FIFO storage, written from the last tracking stage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= trk_rd_q[MEM_LATENCY-1];
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic          fault_q;
    logic [AW-1:0] fault_addr_q;

    // One-cycle fault pulse after a trapped accept, remembering its address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q <= acc && squash;
            if (acc && squash) fault_addr_q <= req_addr_i;
        end
    end

    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;
`else
    assign fault_o      = 1'b0;
    assign fault_addr_o = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory environment,
// byte-array reference model, response scoreboard with a separate monitor.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int DATA_DEPTH  = 4096;
    localparam int MEM_LATENCY = 3;
    localparam int RSP_DEPTH   = MEM_LATENCY + 1;
    localparam int AW          = 2 + $clog2(DATA_DEPTH);
    localparam int MEMB        = 1 << AW;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready_o, req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_rd;
    logic          flush;
    logic          mem_we_o;
    logic [1:0]    mem_data_width_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_write_data_o, mem_read_data;
    logic          rsp_valid_o, rsp_ready;
    logic [3:0]    rsp_rd_o;
    logic [31:0]   rsp_data_o;
    logic          fault_o;
    logic [AW-1:0] fault_addr_o;

    load_store_unit #(.DATA_DEPTH(DATA_DEPTH), .MEM_LATENCY(MEM_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_rd_i(req_rd), .flush_i(flush),
        .mem_we_o(mem_we_o), .mem_data_width_o(mem_data_width_o),
        .mem_addr_o(mem_addr_o), .mem_write_data_o(mem_write_data_o),
        .mem_read_data_i(mem_read_data),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_rd_o(rsp_rd_o), .rsp_data_o(rsp_data_o),
        .fault_o(fault_o), .fault_addr_o(fault_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [AW-1:0] ofs(input logic [AW-1:0] a, input int k);
        return a + AW'(k);
    endfunction

    // ---------------- memory environment (driven only by DUT outputs)
    logic [7:0]  env_mem [MEMB];
    logic [31:0] rd_pipe [MEM_LATENCY];
    logic        env_clr;
    assign mem_read_data = rd_pipe[MEM_LATENCY-1];

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < MEMB; i++) env_mem[i] <= 8'h00;
        end else if (mem_we_o) begin
            env_mem[mem_addr_o] <= mem_write_data_o[7:0];
            if (mem_data_width_o != 2'd0) env_mem[ofs(mem_addr_o, 1)] <= mem_write_data_o[15:8];
            if (mem_data_width_o == 2'd2) begin
                env_mem[ofs(mem_addr_o, 2)] <= mem_write_data_o[23:16];
                env_mem[ofs(mem_addr_o, 3)] <= mem_write_data_o[31:24];
            end
        end
        rd_pipe[0] <= {env_mem[ofs(mem_addr_o, 3)], env_mem[ofs(mem_addr_o, 2)],
                       env_mem[ofs(mem_addr_o, 1)], env_mem[mem_addr_o]};
        for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // ---------------- reference model
    logic [7:0] ref_mem [MEMB];

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } rsp_t;
    rsp_t exp_q [$];

    logic          exp_fault;
    logic [AW-1:0] exp_fault_addr;
    logic          use_exp;
    logic [31:0]   exp_override;
    logic          last_acc;
    logic          last_rsp_valid;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [AW-1:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a];
        b1 = ref_mem[ofs(a, 1)];
        b2 = ref_mem[ofs(a, 2)];
        b3 = ref_mem[ofs(a, 3)];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   return f3[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic bit is_trap(input logic [2:0] f3, input logic [AW-1:0] a);
        return (f3[1:0] == 2'b11) || (f3[1:0] == 2'b01 && a[0])
            || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] rd);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    // One clock cycle: entered at posedge+1 with inputs set, left at next posedge+1.
    task automatic step();
        logic exp_rdy, acc, trap, issue, nxt_fault;
        #2;
        last_rsp_valid = rsp_valid_o;
        exp_rdy = !flush && (req_we || (exp_q.size() < RSP_DEPTH));
        chk("req_ready", req_ready_o, exp_rdy);
        chk("fault", fault_o, exp_fault);
        chk("fault_addr", fault_addr_o, exp_fault_addr);
        acc   = req_valid && req_ready_o;
        trap  = TRAP && is_trap(req_funct3, req_addr);
        issue = acc && !trap && (req_funct3[1:0] != 2'b11);
        chk("mem_we", mem_we_o, issue && req_we);
        if (issue) begin
            chk("mem_width", mem_data_width_o, req_funct3[1:0]);
            chk("mem_addr", mem_addr_o, req_addr);
            if (req_we) begin
                chk("mem_wdata", mem_write_data_o, req_wdata);
                for (int k = 0; k < (1 << req_funct3[1:0]); k++)
                    ref_mem[ofs(req_addr, k)] = req_wdata[8*k +: 8];
            end else begin
                exp_q.push_back('{rd: req_rd,
                                  data: use_exp ? exp_override : model_load(req_funct3, req_addr)});
            end
        end
        nxt_fault = acc && trap;
        last_acc  = acc;
        @(posedge clk);
        exp_fault = nxt_fault;
        if (nxt_fault) exp_fault_addr = req_addr;
        if (flush) exp_q.delete();
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 3'b000, '0, '0, '0);
        repeat (n) step();
    endtask

    task automatic drain(input string name);
        int k = 0;
        drive(1'b0, 1'b0, 3'b000, '0, '0, '0);
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && k < 40) begin
            step();
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor: pops and compares each consumed response
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid_o && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: actual rd=%0d data=0x%0h, required no response (t=%0t)",
                             rsp_rd_o, rsp_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rd", rsp_rd_o, e.rd);
                    chk("rsp_data", rsp_data_o, e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus
    initial begin
        int acc_cnt;
        rst = 1'b1;
        env_clr = 1'b1;
        flush = 1'b0;
        rsp_ready = 1'b1;
        use_exp = 1'b0;
        exp_override = '0;
        exp_fault = 1'b0;
        exp_fault_addr = '0;
        drive(1'b0, 1'b0, 3'b000, '0, '0, '0);
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_rd", rsp_rd_o, 0);
        chk("reset_rsp_data", rsp_data_o, 0);
        chk("reset_fault", fault_o, 0);
        chk("reset_fault_addr", fault_addr_o, 0);
        chk("reset_req_ready", req_ready_o, 0);
        chk("reset_mem_we", mem_we_o, 0);
        env_clr = 1'b0;
        rst = 1'b0;
        idle(1);

        // store word, then LW with latency check
        drive(1'b1, 1'b1, 3'b010, AW'('h10), 32'hDEADBEEF, 4'd0);
        step();
        use_exp = 1'b1;
        exp_override = 32'hDEADBEEF;
        drive(1'b1, 1'b0, 3'b010, AW'('h10), '0, 4'd5);
        step();
        use_exp = 1'b0;
        drive(1'b0, 1'b0, 3'b000, '0, '0, '0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("lw_latency", last_rsp_valid, (k == 4));
        end
        drain("drain_lw");

        // byte/half extension, back-to-back
        use_exp = 1'b1;
        exp_override = 32'hFFFFFFDE; drive(1'b1, 1'b0, 3'b000, AW'('h13), '0, 4'd1); step();
        exp_override = 32'h000000DE; drive(1'b1, 1'b0, 3'b100, AW'('h13), '0, 4'd2); step();
        exp_override = 32'hFFFFDEAD; drive(1'b1, 1'b0, 3'b001, AW'('h12), '0, 4'd3); step();
        exp_override = 32'h0000DEAD; drive(1'b1, 1'b0, 3'b101, AW'('h12), '0, 4'd4); step();
        use_exp = 1'b0;
        drain("drain_ext");

        // backpressure: six loads, only RSP_DEPTH accepted
        rsp_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 3'b100, AW'('h10 + i), '0, 4'(i + 6));
            step();
            if (last_acc) acc_cnt++;
        end
        chk("backpressure_accepts", acc_cnt, RSP_DEPTH);
        idle(2);
        drain("drain_backpressure");

        // flush kills two in-flight loads; a later load returns
        drive(1'b1, 1'b0, 3'b010, AW'('h10), '0, 4'd9);  step();
        drive(1'b1, 1'b0, 3'b010, AW'('h10), '0, 4'd10); step();
        flush = 1'b1;
        drive(1'b1, 1'b0, 3'b010, AW'('h10), '0, 4'd11); step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 3'b000, '0, '0, '0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("flush_no_rsp", last_rsp_valid, 0);
        end
        drive(1'b1, 1'b0, 3'b001, AW'('h12), '0, 4'd12); step();
        drain("drain_after_flush");

        // reset with loads in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 3'b010, AW'('h10), '0, 4'(i + 1));
            step();
        end
        idle(2);
        chk("pre_reset_rsp_valid", rsp_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("midreset_rsp_valid", rsp_valid_o, 0);
        chk("midreset_rsp_rd", rsp_rd_o, 0);
        chk("midreset_rsp_data", rsp_data_o, 0);
        chk("midreset_req_ready", req_ready_o, 0);
        chk("midreset_fault", fault_o, 0);
        exp_q.delete();
        exp_fault = 1'b0;
        exp_fault_addr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("postreset_no_rsp", last_rsp_valid, 0);
        end

        // misaligned word and illegal width
        drive(1'b1, 1'b1, 3'b010, AW'('h4), 32'h11223344, 4'd0); step();
        drive(1'b1, 1'b1, 3'b010, AW'('h8), 32'h55667788, 4'd0); step();
        use_exp = 1'b1;
        exp_override = 32'h88112233;
        drive(1'b1, 1'b0, 3'b010, AW'('h5), '0, 4'd7); step();
        use_exp = 1'b0;
        idle(1);
        chk("fault_addr_misaligned", fault_addr_o, TRAP ? 32'h5 : 32'h0);
        drive(1'b1, 1'b0, 3'b011, AW'('h21), '0, 4'd8); step();
        drive(1'b1, 1'b1, 3'b111, AW'('h4), 32'hCAFEF00D, 4'd0); step();
        drive(1'b1, 1'b0, 3'b010, AW'('h4), '0, 4'd9); step();
        drain("drain_misaligned");

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), AW'($urandom_range(0, 63)),
                  $urandom, 4'($urandom_range(0, 15)));
            step();
        end
        flush = 1'b0;
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline MEM-stage front end for the RV32E core's data memory. Accepts load/store requests from the execute stage over a valid/ready handshake and drives the byte-banked data memory group (`we`, `data_width`, `addr`, `write_data`). It tracks loads in flight through the memory's fixed read latency, then sign- or zero-extends the returned data. Results are buffered in a small response FIFO toward writeback.

## Interface
- `DATA_DEPTH`, 4096: words per memory bank; `AW` = 2+$clog2(DATA_DEPTH) byte-address bits.
- `MEM_LATENCY`, 3: cycles from `mem_addr` presented to `mem_read_data` valid.
- `RSP_DEPTH`, MEM_LATENCY+1: response FIFO entries.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3:
  - [1:0]: 00 byte, 01 half, 10 word, 11 illegal.
  - [2]: unsigned load.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `req_rd`  in  4  load destination register.
- `flush`  in  1  kill all in-flight loads and buffered responses.
- `mem_we`  out  1  memory write enable.
- `mem_data_width`  out  2  `DATAWIDTH_BYTE/SHORT/WORD`.
- `mem_addr`  out  AW  equals `req_addr` (combinational).
- `mem_write_data`  out  32  equals `req_wdata` (combinational).
- `mem_read_data`  in  32  memory group read data.
- `rsp_valid`  out  1  response at FIFO head.
- `rsp_ready`  in  1  writeback consumes head when `rsp_valid && rsp_ready`.
- `rsp_rd`  out  4  destination register.
- `rsp_data`  out  32  extended load data.
- `fault`  out  1  one-cycle pulse; tied 0 unless the trap macro is defined.
- `fault_addr`  out  AW  address of the last faulting request.

## Operation
- Accept: `acc = req_valid && req_ready`.
- Store accept: `mem_we = 1` in the same cycle. No tracking entry, no response.
- Load accept: `mem_we = 0`. Push {rd, funct3} into a MEM_LATENCY-deep tracking shift register; entry valid = 1.
- Tracking stage MEM_LATENCY: when its entry is valid, extract data from `mem_read_data` and write it into the FIFO:
  - byte: bits [7:0], extended by bit 7 unless unsigned.
  - half: bits [15:0], extended by bit 15 unless unsigned.
  - word: pass through.
- Width mapping: funct3[1:0] 00/01/10 → BYTE/SHORT/WORD.
- Illegal width (11): request accepted. No memory write, no tracking entry, no response. Raises `fault` when trapping is enabled.
- `req_ready`:
  - 0 when `flush`.
  - Otherwise 1 for stores.
  - Otherwise 1 for loads only if (valid tracking entries + FIFO count) < RSP_DEPTH. The same-cycle pop is not credited.
  - Depends on `req_we`/`flush`, never on `req_valid`.
- `mem_we` is 0 whenever no store is accepted. Misaligned accesses pass through unchanged; the memory group handles them.
- `flush`: all tracking valids and FIFO count cleared at the edge. `rsp_valid` is 0 in the next cycle. A store accepted before the flush cycle is not undone.
- FIFO: simultaneous push and pop leaves the count unchanged. Never overflows, guaranteed by the `req_ready` rule.

## Timing
- Reset state: all outputs low/zero, including `rsp_valid`, `rsp_rd`, `rsp_data`, `fault`, `fault_addr`. Tracking and FIFO are empty.
- Reset mid-operation discards all in-flight loads.
- Load latency: accepted at cycle T; data sampled at T+MEM_LATENCY. `rsp_valid` rises at T+MEM_LATENCY+1 (T+4 by default) if the FIFO was empty.
- Back-to-back loads give one response per cycle, in order.
- Store: write occurs at the accept edge.
- A load after a store to the same address returns the new data (in-order single port).
- `fault` rises the cycle after the faulting accept, for 1 cycle. `fault_addr` updates on that same edge.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Trapping requests: half with addr[0]=1, word with addr[1:0]≠0, or illegal width.
  - Such a request is accepted but not issued: `mem_we` = 0 and no tracking entry.
  - `fault` pulses and `fault_addr` captures `req_addr`.
- Undefined: misaligned accesses are issued normally. Illegal width is silently dropped. `fault` and `fault_addr` are constant 0.

## Test plan
- Store word 0xDEADBEEF to addr 0x10, then LW rd=5 at 0x10 → 4 cycles after accept: `rsp_valid` = 1, `rsp_rd` = 5, `rsp_data` = 0xDEADBEEF.
- From the same memory, LB at 0x13 → 0xFFFFFFDE. LBU at 0x13 → 0x000000DE. LH at 0x12 → 0xFFFFDEAD. LHU at 0x12 → 0x0000DEAD.
- Hold `rsp_ready` = 0 and issue 6 consecutive loads → exactly 4 accepted and `req_ready` = 0 for the load. Then release `rsp_ready` → 4 ordered responses.
- Issue 2 loads, assert `flush` 2 cycles later → no `rsp_valid` ever appears for them. A new load issued after the flush returns normally.
- Assert `rst` while 3 loads are in flight → all outputs 0 immediately. No response after release.
- Issue LW at addr 0x5:
  - With `LSU_MISALIGN_TRAP_EN`: `fault` pulses, `fault_addr` = 0x5, no response.
  - Without it: the misaligned word is returned.
